// File: rtl/multdiv_unit_if.sv
// Request/response bundle between instruction decode and the multdiv_unit.
// Decode drives the master side; the unit sits on the slave side.
interface multdiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [TAGW-1:0]  ctrl_tag_in;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic [TAGW-1:0]  ctrl_tag_out;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_tag_in,
    input  data_result, data_exception, data_resultRDY, ctrl_tag_out, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB, ctrl_tag_in,
    output data_result, data_exception, data_resultRDY, ctrl_tag_out, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring) unit, one step per cycle.
// Optional MULTDIV_EARLY_DIV0_EN: divide-by-zero completes immediately instead of running all steps.
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input logic          clock,
  input logic          reset_n,
  multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic             start, early_div0, last_step;
  logic             is_div_q, neg_q, div0_q, ovf_q;
  logic [5:0]       count_q;
  logic [WIDTH-1:0] upper_q, lower_q, opnd_q;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic [TAGW-1:0]  tag_q;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   upper_n, lower_n, quot_s;
  logic [2*WIDTH-1:0] prod_u, prod_s;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_exc;

  // Both requests at once is illegal and simply produces no start.
  assign start     = bus.ctrl_MULT ^ bus.ctrl_DIV;
  assign last_step = (count_q == 6'(WIDTH-1));
  assign mag_a     = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign mag_b     = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

`ifdef MULTDIV_EARLY_DIV0_EN
  assign early_div0 = bus.ctrl_DIV && (bus.data_operandB == '0);
`else
  assign early_div0 = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = early_div0 ? DONE : RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One datapath step: upper/lower form a 2*WIDTH shift register shared by both operations.
  always_comb begin
    mul_sum   = {1'b0, upper_q} + (lower_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {upper_q, lower_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (is_div_q) begin
      if (!div_diff[WIDTH]) begin
        upper_n = div_diff[WIDTH-1:0];
        lower_n = {lower_q[WIDTH-2:0], 1'b1};
      end else begin
        upper_n = div_shift[WIDTH-1:0];
        lower_n = {lower_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      upper_n = mul_sum[WIDTH:1];
      lower_n = {mul_sum[0], lower_q[WIDTH-1:1]};
    end
  end

  // Sign restoration and exception rules, evaluated on the last step's output.
  always_comb begin
    prod_u = {upper_n, lower_n};
    prod_s = neg_q ? -prod_u : prod_u;
    quot_s = neg_q ? -lower_n : lower_n;
    if (is_div_q) begin
      fin_res = div0_q ? '0 : quot_s;
      fin_exc = div0_q | ovf_q;
    end else begin
      fin_res = prod_s[WIDTH-1:0];
      fin_exc = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
      upper_q  <= '0;
      lower_q  <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          is_div_q <= bus.ctrl_DIV;
          neg_q    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          div0_q   <= bus.ctrl_DIV && (bus.data_operandB == '0);
          ovf_q    <= bus.ctrl_DIV && (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}})
                      && (bus.data_operandB == '1);
          count_q  <= '0;
          upper_q  <= '0;
          lower_q  <= bus.ctrl_DIV ? mag_a : mag_b;
          opnd_q   <= bus.ctrl_DIV ? mag_b : mag_a;
          tag_q    <= bus.ctrl_tag_in;
          if (early_div0) begin
            result_q <= '0;
            exc_q    <= 1'b1;
          end
        end
        RUN: begin
          upper_q <= upper_n;
          lower_q <= lower_n;
          count_q <= count_q + 6'd1;
          if (last_step) begin
            result_q <= fin_res;
            exc_q    <= fin_exc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.ctrl_tag_out   = tag_q;
  assign bus.data_resultRDY = (state_q == DONE);
  // The stall covers the request cycle itself, hence the OR with start.
  assign bus.busy           = (state_q != IDLE) || start;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: stimulus queues expected results,
// a monitor compares them whenever data_resultRDY is seen.
module tb_multdiv_unit;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    logic [4:0]  tag;
    int          lat;
    int          start_cycle;
  } exp_t;

`ifdef MULTDIV_EARLY_DIV0_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  multdiv_unit_if #(.WIDTH(32), .TAGW(5)) bus ();

  multdiv_unit #(.WIDTH(32), .TAGW(5)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && bus.data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 64'(bus.data_resultRDY), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result",  64'(bus.data_result), 64'(e.res));
        check("exception", 64'(bus.data_exception), 64'(e.exc));
        check("tag_out", 64'(bus.ctrl_tag_out), 64'(e.tag));
        check("latency", 64'(cycle - e.start_cycle + 1), 64'(e.lat));
      end
    end
  end

  // Drive one request for a single cycle; optionally queue its expected completion.
  task automatic issue(input logic mult, input logic div, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input bit push,
                       input logic [31:0] res, input logic exc, input int lat);
    @(negedge clock);
    bus.ctrl_MULT     = mult;
    bus.ctrl_DIV      = div;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_tag_in   = tag;
    if (push) sb.push_back('{res: res, exc: exc, tag: tag, lat: lat, start_cycle: cycle + 1});
    #1 check("busy_on_request", 64'(bus.busy), 64'(mult ^ div));
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check(name, 64'(bus.data_resultRDY), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    bus.ctrl_tag_in   = '0;
    repeat (3) @(negedge clock);
    check("rst_result", 64'(bus.data_result), 64'd0);
    check("rst_exc",    64'(bus.data_exception), 64'd0);
    check("rst_rdy",    64'(bus.data_resultRDY), 64'd0);
    check("rst_tag",    64'(bus.ctrl_tag_out), 64'd0);
    check("rst_busy",   64'(bus.busy), 64'd0);
    reset_n = 1'b1;

    // First multiply: busy must stay high from the start edge through DONE.
    issue(1, 0, 32'd7, -32'sd6, 5'd5, 1, 32'hFFFF_FFD6, 0, 33);
    for (int i = 0; i < 33; i++) begin
      @(negedge clock);
      check("busy_running", 64'(bus.busy), 64'd1);
    end
    wait_drain();
    @(negedge clock);
    check("busy_after", 64'(bus.busy), 64'd0);
    check("hold_result", 64'(bus.data_result), 64'hFFFF_FFD6);
    check("hold_tag", 64'(bus.ctrl_tag_out), 64'd5);

    issue(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd1, 1, 32'h0, 1, 33);  wait_drain();
    issue(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1, 32'h1, 0, 33);  wait_drain();
    issue(1, 0, 32'h8000_0000, 32'h1,         5'd3, 1, 32'h8000_0000, 0, 33); wait_drain();
    issue(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 32'h8000_0000, 1, 33); wait_drain();
    issue(0, 1, -32'sd17, 32'd5,              5'd6, 1, 32'hFFFF_FFFD, 0, 33); wait_drain();
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1, 32'h8000_0000, 1, 33); wait_drain();
    issue(0, 1, 32'd9, 32'd0,                 5'd8, 1, 32'h0, 1, DIV0_LAT); wait_drain();
    issue(0, 1, 32'd7, 32'd9,                 5'd9, 1, 32'h0, 0, 33);  wait_drain();
    issue(0, 1, 32'd100, -32'sd7,             5'd10, 1, 32'hFFFF_FFF2, 0, 33); wait_drain();

    // Reset in the middle of a multiply: outputs clear at once, nothing completes.
    issue(1, 0, 32'd1000, 32'd1000, 5'd11, 0, 32'h0, 0, 0);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_result", 64'(bus.data_result), 64'd0);
    check("midrst_exc",    64'(bus.data_exception), 64'd0);
    check("midrst_rdy",    64'(bus.data_resultRDY), 64'd0);
    check("midrst_tag",    64'(bus.ctrl_tag_out), 64'd0);
    check("midrst_busy",   64'(bus.busy), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    quiet(40, "rdy_after_reset");
    issue(1, 0, 32'd3, 32'd4, 5'd2, 1, 32'd12, 0, 33); wait_drain();

    // Both requests together: no start.
    issue(1, 1, 32'd5, 32'd5, 5'd20, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("busy_illegal", 64'(bus.busy), 64'd0);
    end
    check("tag_illegal", 64'(bus.ctrl_tag_out), 64'd2);
    quiet(35, "rdy_illegal");

    // A second divide during RUN is ignored.
    issue(0, 1, -32'sd17, 32'd5, 5'd7, 1, 32'hFFFF_FFFD, 0, 33);
    repeat (5) @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 32'd1000;
    bus.data_operandB = 32'd1;
    bus.ctrl_tag_in   = 5'd3;
    @(posedge clock);
    #1 bus.ctrl_DIV = 1'b0;
    wait_drain();
    quiet(40, "rdy_ignored_start");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Iterative signed 32-bit multiply/divide unit in the execute stage, directly downstream of instruction decode. Decode raises `ctrl_MULT` for R-type ALU_op 00110 (mul) or `ctrl_DIV` for 00111 (div). The unit runs a multi-cycle shift-add or restoring-division sequence and holds the pipeline stalled while it runs. It then returns the result, an exception flag and the destination-register tag to writeback. On exception, writeback redirects the write to the status register $r30.

## Interface
- `WIDTH`, 32, operand and result width; the iteration count equals `WIDTH`
- `TAGW`, 5, destination-register tag width
- `clock`  in  1  rising-edge clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ctrl_MULT`  in  1  start a multiply; single-cycle request
- `ctrl_DIV`  in  1  start a divide; single-cycle request
- `data_operandA`  in  WIDTH  multiplicand or dividend (rs), signed
- `data_operandB`  in  WIDTH  multiplier or divisor (rt), signed
- `ctrl_tag_in`  in  TAGW  destination register (rd), captured at start
- `data_result`  out  WIDTH  product low word or quotient
- `data_exception`  out  1  overflow or divide error; valid while `data_resultRDY` is high
- `data_resultRDY`  out  1  one-cycle completion pulse
- `ctrl_tag_out`  out  TAGW  captured rd; stable from start until the next start
- `busy`  out  1  unit is occupied; the upstream pipeline must stall

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN:
  - Trigger: exactly one of `ctrl_MULT`/`ctrl_DIV` is high at a clock edge.
  - Latches operands, operation type and tag.
  - Takes operand magnitudes and records the result sign; clears the 6-bit iteration counter to 0.
- Both requests high together: illegal. No start; state stays IDLE; outputs unchanged.
- RUN, multiply: one radix-2 shift-add step per cycle on magnitudes, into a 2·WIDTH-bit accumulator.
- RUN, divide: one restoring-division step per cycle (shift, trial subtract, restore), producing quotient and remainder.
- RUN → DONE when the counter reaches WIDTH−1, i.e. after WIDTH steps.
- DONE:
  - Applies the sign and drives `data_result` / `data_exception`.
  - Pulses `data_resultRDY`; returns to IDLE on the next edge.
- Arithmetic rules:
  - mul: result = low WIDTH bits of the signed 2·WIDTH product. Exception = product does not sign-extend from bit WIDTH−1.
  - div: quotient truncates toward zero; remainder is discarded.
  - B = 0: result 0, exception 1.
  - A = 0x80000000 and B = −1: result 0x80000000, exception 1.
- Start requests while in RUN or DONE are ignored. No queueing; decode must not issue them while `busy` is high.
- `data_result`, `data_exception` and `ctrl_tag_out` hold their values after DONE until the next accepted start.
- Reset (`reset_n` low, asynchronous, at any time including mid-RUN):
  - Returns the FSM to IDLE and clears the counter.
  - `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `ctrl_tag_out`=0, `busy`=0.
  - Any in-flight operation is discarded; no completion pulse follows.

## Timing
- Start is sampled at edge N.
- `busy` is high from just after edge N through the DONE cycle. It is combinationally OR'd with the start request, so the stall also covers the request cycle.
- Steps execute at edges N+1 … N+WIDTH.
- DONE is entered at edge N+WIDTH. `data_resultRDY` is high for exactly one cycle, between edges N+WIDTH and N+WIDTH+1.
- Latency: WIDTH+1 cycles from request to the result-valid edge (33 at default).
- A new start is accepted no earlier than edge N+WIDTH+1; back-to-back issue gives 33-cycle throughput.
- Outputs are registered; there is no combinational path from inputs to `data_result`.

## Configuration
- Macro: `MULTDIV_EARLY_DIV0_EN`.
- Defined:
  - A divide with B = 0 goes IDLE → DONE at edge N and skips RUN.
  - `data_resultRDY` pulses in cycle N+1 with result 0 and exception 1.
  - `busy` is high for that one cycle only.
- Undefined:
  - Divide-by-zero runs the full WIDTH steps; completion timing is the same as any divide.
  - The final result is forced to 0 with exception 1.
- All other operations are identical either way.

## Test plan
- mul A=7, B=−6, tag=5 → RDY pulse 33 cycles after start; result 0xFFFFFFD6 (−42), exception 0, tag_out 5, `busy` high throughout.
- mul A=0x00010000, B=0x00010000 → result 0x00000000, exception 1 (overflow). mul A=−1, B=−1 → result 1, exception 0.
- div A=−17, B=5 → result 0xFFFFFFFD (−3), exception 0. div A=0x80000000, B=−1 → result 0x80000000, exception 1.
- div A=9, B=0 → result 0, exception 1. RDY arrives at cycle 33 without the macro and at cycle 1 with `MULTDIV_EARLY_DIV0_EN`.
- Assert `reset_n` low at step 10 of a multiply → all outputs read 0 immediately; no RDY pulse follows; a new mul 3×4 then completes with 12 after 33 cycles.
- `ctrl_MULT` and `ctrl_DIV` high together → no start, `busy` stays 0. A second `ctrl_DIV` mid-RUN → ignored, and the first result is unaffected.
